// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Inter-stage pipeline register with stall/flush control,
//               deferred flush, NOP bubble injection and saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int          WIDTH      = 32,
    parameter int          LANES      = 3,
    parameter logic [31:0] NOP_VALUE  = 32'h00000013,
    parameter int          FLUSH_PRIO = 0,
    parameter int          CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   cnt_clr,
    input  logic                   valid_in,
    input  logic [LANES*WIDTH-1:0] din,
    output logic                   valid_out,
    output logic [LANES*WIDTH-1:0] dout,
    output logic                   flush_pending,
    output logic                   killed,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    localparam logic [WIDTH-1:0]       NOP_W   = WIDTH'(NOP_VALUE);
    localparam logic [LANES*WIDTH-1:0] BUBBLE  = (LANES*WIDTH)'(NOP_W);
    localparam logic [CNT_W-1:0]       CNT_MAX = '1;

    logic fl_eff;
    logic do_flush;
    logic do_load;
    logic set_pending;

    assign fl_eff = flush | flush_pending;

    // Exactly one of HOLD / FLUSH / LOAD per edge; HOLD is the residual case.
    generate
        if (FLUSH_PRIO != 0) begin : g_flush_first
            assign do_flush    = fl_eff;
            assign do_load     = ~fl_eff & ~stall;
            assign set_pending = 1'b0;
        end else begin : g_stall_first
            assign do_flush    = ~stall & fl_eff;
            assign do_load     = ~stall & ~fl_eff;
            assign set_pending = stall & flush;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout          <= '0;
            valid_out     <= 1'b0;
            flush_pending <= 1'b0;
            killed        <= 1'b0;
        end else begin
            killed <= 1'b0;
            if (do_flush) begin
                dout          <= BUBBLE;
                valid_out     <= 1'b0;
                flush_pending <= 1'b0;
                killed        <= valid_out;
            end else if (do_load) begin
                dout      <= din;
                valid_out <= valid_in;
            end else if (set_pending) begin
                flush_pending <= 1'b1;
            end
        end
    end

    // A same-edge clear wins over any increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && valid_out && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (do_flush && valid_out && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Scoreboard bench driving a stall-priority and a flush-priority
//               instance side by side with identical stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int          DW  = 96;
    localparam logic [95:0] BUB = 96'h13;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, flush, cnt_clr, valid_in;
    logic [DW-1:0] din;

    logic [1:0][DW-1:0] dout;
    logic [1:0]         valid_out, pend, killed;
    logic [1:0][3:0]    sc, fc;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .LANES(3), .NOP_VALUE(32'h13), .FLUSH_PRIO(0), .CNT_W(4)) u_prio0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .valid_in(valid_in), .din(din), .valid_out(valid_out[0]), .dout(dout[0]),
        .flush_pending(pend[0]), .killed(killed[0]), .stall_cnt(sc[0]), .flush_cnt(fc[0])
    );

    pipe_stage_reg #(.WIDTH(32), .LANES(3), .NOP_VALUE(32'h13), .FLUSH_PRIO(1), .CNT_W(4)) u_prio1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .valid_in(valid_in), .din(din), .valid_out(valid_out[1]), .dout(dout[1]),
        .flush_pending(pend[1]), .killed(killed[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1])
    );

    // Reference state for both instances, advanced one edge at a time.
    logic [1:0][DW-1:0] m_dout;
    logic [1:0]         m_valid, m_pend, m_kill;
    logic [1:0][3:0]    m_sc, m_fc;

    typedef struct {
        string              name;
        logic [1:0][DW-1:0] dout;
        logic [1:0]         valid, pend, kill;
        logic [1:0][3:0]    sc, fc;
    } exp_t;

    exp_t sb[$];

    task automatic model_reset();
        m_dout = '0; m_valid = '0; m_pend = '0; m_kill = '0; m_sc = '0; m_fc = '0;
    endtask

    task automatic model_edge(input int i, input int prio);
        logic fl, hold, fls;
        fl = flush | m_pend[i];
        if (prio == 0) begin
            hold = stall;
            fls  = !stall && fl;
        end else begin
            fls  = fl;
            hold = !fl && stall;
        end
        if (cnt_clr) begin
            m_sc[i] = 4'd0;
            m_fc[i] = 4'd0;
        end else begin
            if (stall && m_valid[i] && m_sc[i] != 4'd15) m_sc[i] = m_sc[i] + 4'd1;
            if (fls && m_valid[i] && m_fc[i] != 4'd15)   m_fc[i] = m_fc[i] + 4'd1;
        end
        if (fls) begin
            m_kill[i]  = m_valid[i];
            m_dout[i]  = BUB;
            m_valid[i] = 1'b0;
            m_pend[i]  = 1'b0;
        end else if (hold) begin
            m_kill[i] = 1'b0;
            if (prio == 0 && flush) m_pend[i] = 1'b1;
        end else begin
            m_kill[i]  = 1'b0;
            m_dout[i]  = din;
            m_valid[i] = valid_in;
        end
    endtask

    task automatic push(input string name);
        exp_t e;
        e.name = name; e.dout = m_dout; e.valid = m_valid; e.pend = m_pend;
        e.kill = m_kill; e.sc = m_sc; e.fc = m_fc;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            for (int i = 0; i < 2; i++) begin
                check($sformatf("%s.d%0d.dout", e.name, i),  dout[i],              e.dout[i]);
                check($sformatf("%s.d%0d.valid", e.name, i), DW'(valid_out[i]),    DW'(e.valid[i]));
                check($sformatf("%s.d%0d.pend", e.name, i),  DW'(pend[i]),         DW'(e.pend[i]));
                check($sformatf("%s.d%0d.kill", e.name, i),  DW'(killed[i]),       DW'(e.kill[i]));
                check($sformatf("%s.d%0d.scnt", e.name, i),  DW'(sc[i]),           DW'(e.sc[i]));
                check($sformatf("%s.d%0d.fcnt", e.name, i),  DW'(fc[i]),           DW'(e.fc[i]));
            end
        end
    endtask

    task automatic step(input string name, input logic s, input logic f, input logic c,
                        input logic vi, input logic [DW-1:0] d);
        @(negedge clk);
        stall = s; flush = f; cnt_clr = c; valid_in = vi; din = d;
        model_edge(0, 0);
        model_edge(1, 1);
        push(name);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0; valid_in = 1'b0; din = '0;
        model_reset();
        repeat (2) @(negedge clk);
        push("reset");
        compare_head();
        rst = 1'b1;

        // Plain load, one-cycle latency
        step("load", 0, 0, 0, 1, {32'd3, 32'd2, 32'h00500093});
        check("load.lit.dout", dout[0], {32'd3, 32'd2, 32'h00500093});
        check("load.lit.valid", DW'(valid_out[0]), DW'(1'b1));

        // Stall+flush for two cycles, then release
        step("stfl1", 1, 1, 0, 1, 96'hDEAD_BEEF_0123_4567_89AB_CDEF);
        check("stfl1.lit.pend0", DW'(pend[0]), DW'(1'b1));
        check("stfl1.lit.kill1", DW'(killed[1]), DW'(1'b1));
        step("stfl2", 1, 1, 0, 1, 96'h1111_2222_3333_4444_5555_6666);
        check("stfl2.lit.dout0", dout[0], {32'd3, 32'd2, 32'h00500093});
        check("stfl2.lit.kill1", DW'(killed[1]), DW'(1'b0));
        check("stfl2.lit.pend1", DW'(pend[1]), DW'(1'b0));
        step("apply", 0, 0, 0, 1, 96'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD);
        check("apply.lit.dout0", dout[0], BUB);
        check("apply.lit.kill0", DW'(killed[0]), DW'(1'b1));
        check("apply.lit.fcnt0", DW'(fc[0]), DW'(4'd1));
        step("post", 0, 0, 0, 1, 96'h0000_00A1_0000_00A2_0000_00A3);
        check("post.lit.kill0", DW'(killed[0]), DW'(1'b0));

        // Flush of an invalid entry
        step("ld_inv", 0, 0, 0, 0, 96'h55);
        step("fl_inv", 0, 1, 0, 1, 96'h66);
        check("fl_inv.lit.kill0", DW'(killed[0]), DW'(1'b0));
        check("fl_inv.lit.fcnt0", DW'(fc[0]), DW'(4'd1));

        // Stall counter saturation and clear-under-stall
        step("clr", 0, 0, 1, 1, 96'h77);
        for (int k = 0; k < 20; k++)
            step($sformatf("stall%0d", k), 1, 0, 0, 1, DW'(k));
        check("sat.lit.scnt0", DW'(sc[0]), DW'(4'd15));
        step("stclr", 1, 0, 1, 1, 96'h88);
        check("stclr.lit.scnt0", DW'(sc[0]), DW'(4'd0));

        // Asynchronous reset while a flush is pending
        step("ldAA", 0, 0, 0, 1, {3{32'hAAAA_AAAA}});
        step("pend", 1, 1, 0, 1, 96'h99);
        check("pend.lit.pend0", DW'(pend[0]), DW'(1'b1));
        check("pend.lit.dout0", dout[0], {3{32'hAAAA_AAAA}});
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        push("async_rst");
        compare_head();
        stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0; valid_in = 1'b1; din = 96'hC0FFEE;
        rst = 1'b1;
        model_edge(0, 0);
        model_edge(1, 1);
        push("post_rst");
        @(posedge clk);
        #1;
        compare_head();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
